// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Fetch-stage sequencer. Owns the PC, issues one outstanding
//            instruction-memory request at a time, holds each fetched word
//            until decode accepts it, and applies branch/jump redirects,
//            including a redirect that arrives while a fetch is in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous active-high reset
//   imem_req       out  1   fetch request (held until imem_ack)
//   imem_addr      out  32  fetch address (current PC)
//   imem_ack       in   1   one-cycle response pulse, imem_rdata valid with it
//   imem_rdata     in   32  fetched instruction word
//   inst_valid     out  1   instruction available to decode
//   inst           out  32  fetched instruction
//   inst_pc        out  32  address of inst
//   inst_ready     in   1   decode accepts inst this cycle
//   redirect_valid in   1   one-cycle redirect request
//   redirect_pc    in   32  redirect target
//   perf_fetched   out  32  (FETCH_PERF_CNT_EN) accepted instructions
//   perf_squashed  out  32  (FETCH_PERF_CNT_EN) discarded/squashed fetches
//
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_REQ   = 2'd1,
        c_VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_inst_pc;
    logic [31:0] w_inst_pc_nxt;
    logic        r_inst_valid;
    logic        w_inst_valid_nxt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_pc         <= RESET_PC;
            r_pend       <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_nxt       = r_pend;
        w_pend_pc_nxt    = r_pend_pc;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;

        case (r_state)
            c_IDLE: begin
                // Acks seen here belong to a request from before reset.
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
                w_state_nxt = c_REQ;
            end

            c_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        // A same-cycle redirect is newer than any pending one.
                        w_pc_nxt   = redirect_pc;
                        w_pend_nxt = 1'b0;
                    end else if (r_pend) begin
                        w_pc_nxt   = r_pend_pc;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_inst_nxt       = imem_rdata;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + PC_STEP;
                        w_state_nxt      = c_VALID;
                    end
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn, so remember the
                    // target and drop the response when it arrives.
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = redirect_pc;
                end
            end

            c_VALID: begin
                if (redirect_valid) begin
                    w_inst_valid_nxt = 1'b0;
                    w_pc_nxt         = redirect_pc;
                    w_state_nxt      = c_REQ;
                end else if (inst_ready) begin
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = c_REQ;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign imem_req   = (r_state == c_REQ);
    assign imem_addr  = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
    logic        w_fetch_hs;
    logic        w_squash;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_squashed;

    assign w_fetch_hs = r_inst_valid && inst_ready && !redirect_valid;
    assign w_squash   = ((r_state == c_REQ) && imem_ack && (redirect_valid || r_pend))
                     || ((r_state == c_VALID) && redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched  <= 32'd0;
            r_perf_squashed <= 32'd0;
        end else begin
            if (w_fetch_hs) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_squash) begin
                r_perf_squashed <= r_perf_squashed + 32'd1;
            end
        end
    end

    assign perf_fetched  = r_perf_fetched;
    assign perf_squashed = r_perf_squashed;
`else
    // Counters compiled out; no perf ports or registers exist.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer: directed scenarios plus
//            a randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks;
    int failures;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Advance one clock; inputs set afterwards are stable for the next edge,
    // outputs read afterwards reflect the state just registered.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 32'd0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        tick(); // IDLE lasts one cycle
    endtask

    // Single-cycle memory, decode always ready: addresses 0,1,2,3.
    task automatic test_sequential();
        inst_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_req n=%0d got=%b exp=1", n, imem_req); end
            checks++; if (imem_addr !== 32'(n)) begin failures++; $display("FAIL seq_addr n=%0d got=%h exp=%h", n, imem_addr, 32'(n)); end
            imem_ack = 1'b1; imem_rdata = mem_word(32'(n));
            tick();
            imem_ack = 1'b0;
            checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL seq_valid n=%0d got=%b exp=1", n, inst_valid); end
            checks++; if (inst !== mem_word(32'(n))) begin failures++; $display("FAIL seq_inst n=%0d got=%h exp=%h", n, inst, mem_word(32'(n))); end
            checks++; if (inst_pc !== 32'(n)) begin failures++; $display("FAIL seq_inst_pc n=%0d got=%h exp=%h", n, inst_pc, 32'(n)); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_req_in_valid n=%0d got=%b exp=0", n, imem_req); end
            tick();
        end
        inst_ready = 1'b0;
    endtask

    // Decode stalls for 5 cycles with an instruction held.
    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = mem_word(32'd4);
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst !== mem_word(32'd4) || inst_pc !== 32'd4) begin
                failures++; $display("FAIL stall_hold i=%0d got=%b/%h/%h exp=1/%h/4", i, inst_valid, inst, inst_pc, mem_word(32'd4)); end
            checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd5) begin
                failures++; $display("FAIL stall_req i=%0d got=%b/%h exp=0/5", i, imem_req, imem_addr); end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
            failures++; $display("FAIL stall_release got=%b/%h exp=1/5", imem_req, imem_addr); end
    endtask

    // Redirect while waiting for a slow ack: that ack's data is dropped.
    task automatic test_redirect_in_req();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
                failures++; $display("FAIL rdr_req_hold i=%0d got=%b/%h exp=1/5", i, imem_req, imem_addr); end
            tick();
        end
        imem_ack = 1'b1; imem_rdata = mem_word(32'd5);
        tick();
        imem_ack = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdr_drop got=%b exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++; $display("FAIL rdr_new_req got=%b/%h exp=1/40", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = mem_word(32'h40);
        tick();
        imem_ack = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== mem_word(32'h40)) begin
            failures++; $display("FAIL rdr_target got=%b/%h/%h exp=1/40/%h", inst_valid, inst_pc, inst, mem_word(32'h40)); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    // Same-cycle redirect beats an older pending one.
    task automatic test_redirect_with_ack();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h41);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        clear_inputs();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdr_ack_drop got=%b exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            failures++; $display("FAIL rdr_ack_addr got=%b/%h exp=1/80", imem_req, imem_addr); end
    endtask

    // Redirect while an instruction is held squashes it.
    task automatic test_redirect_in_valid();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h80);
        tick();
        imem_ack = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) begin
            failures++; $display("FAIL rdv_held got=%b/%h exp=1/80", inst_valid, inst_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h10; inst_ready = 1'b1;
        tick();
        clear_inputs();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdv_squash got=%b exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            failures++; $display("FAIL rdv_addr got=%b/%h exp=1/10", imem_req, imem_addr); end
    endtask

    // Reset mid-request, then a stale ack one cycle later.
    task automatic test_reset_mid_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle got=%b/%b exp=0/0", imem_req, inst_valid); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale_ack got=%b exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            failures++; $display("FAIL rstmid_addr got=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    // Fetch at 0xFFFFFFFF wraps the next address to 0.
    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'd0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        checks++; if (imem_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_top got=%h exp=ffffffff", imem_addr); end
        imem_ack = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFF);
        tick();
        imem_ack = 1'b0;
        checks++; if (inst_pc !== 32'hFFFF_FFFF || inst_valid !== 1'b1) begin
            failures++; $display("FAIL wrap_inst_pc got=%b/%h exp=1/ffffffff", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    // ------------------------------------------------------------------------
    // Randomized run. The model thinks in fetch transactions: an outstanding
    // fetch (address, whether it has been overtaken by a redirect and to
    // where) and a delivered instruction waiting for decode.
    // ------------------------------------------------------------------------
    task automatic test_random();
        bit          m_startup;   // one quiet cycle after reset
        bit          m_fetching;
        logic [31:0] m_addr;
        bit          m_stale;
        logic [31:0] m_stale_to;
        bit          m_have;
        logic [31:0] m_inst;
        logic [31:0] m_inst_pc;
        bit          r_in;

        do_reset();
        m_startup = 1; m_fetching = 0; m_addr = 32'd0;
        m_stale = 0; m_stale_to = 32'd0; m_have = 0;
        m_inst = 32'd0; m_inst_pc = 32'd0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Compare DUT against the model's current view.
            checks++; if (imem_req !== m_fetching) begin
                failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req, m_fetching); end
            if (m_fetching) begin
                checks++; if (imem_addr !== m_addr) begin
                    failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_addr); end
            end
            checks++; if (inst_valid !== m_have) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, m_have); end
            if (m_have) begin
                checks++; if (inst !== m_inst || inst_pc !== m_inst_pc) begin
                    failures++; $display("FAIL rnd_inst cyc=%0d got=%h@%h exp=%h@%h", cyc, inst, inst_pc, m_inst, m_inst_pc); end
            end

            // New random inputs.
            r_in           = ($urandom_range(0, 299) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
            inst_ready     = ($urandom_range(0, 1) == 1);
            if (m_fetching) begin
                imem_ack   = ($urandom_range(0, 1) == 1);
                imem_rdata = mem_word(m_addr);
            end else begin
                imem_ack   = ($urandom_range(0, 9) == 0);
                imem_rdata = $urandom;
            end
            rst = r_in;

            // Model update for this edge.
            if (r_in) begin
                m_startup = 1; m_fetching = 0; m_addr = 32'd0;
                m_stale = 0; m_have = 0;
            end else if (m_startup) begin
                if (redirect_valid) m_addr = redirect_pc;
                m_startup  = 0;
                m_fetching = 1;
            end else if (m_fetching) begin
                if (imem_ack) begin
                    if (redirect_valid || m_stale) begin
                        m_addr  = redirect_valid ? redirect_pc : m_stale_to;
                        m_stale = 0;
                    end else begin
                        m_have     = 1;
                        m_inst     = imem_rdata;
                        m_inst_pc  = m_addr;
                        m_addr     = m_addr + 32'd1;
                        m_fetching = 0;
                    end
                end else if (redirect_valid) begin
                    m_stale    = 1;
                    m_stale_to = redirect_pc;
                end
            end else if (m_have) begin
                if (redirect_valid || inst_ready) begin
                    if (redirect_valid) m_addr = redirect_pc;
                    m_have     = 0;
                    m_fetching = 1;
                end
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_in_req();
        test_redirect_with_ack();
        test_redirect_in_valid();
        test_reset_mid_req();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
